// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for the shared 32-bit valid/ready memory bus.
// Serialises CPU/DMA transactions, registers each response and bounds downstream latency.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic        grant,
  output logic        err_timeout,
  input  logic        err_clear
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state;
  state_t               state_next;
  logic                 prio;
  logic                 pick;
  logic                 do_grant;
  logic                 done_ok;
  logic                 done_to;
  logic [CNT_WIDTH-1:0] cnt;
  logic [31:0]          resp_data;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // prio breaks ties; it starts at requester 0 and then points away from the last winner
  always_comb begin
    state_next = state;
    pick       = 1'b0;
    do_grant   = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    case (state)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          do_grant   = 1'b1;
          pick       = (m0_valid && m1_valid) ? prio : m1_valid;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (s_ready) begin
          done_ok    = 1'b1;
          state_next = RESP;
        end else if (cnt == CNT_LAST) begin
          done_to    = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    s_valid  = (state == BUSY);
    m0_ready = (state == RESP) && !grant && m0_valid;
    m1_ready = (state == RESP) &&  grant && m1_valid;
    m0_rdata = m0_ready ? resp_data : 32'h0;
    m1_rdata = m1_ready ? resp_data : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grant       <= 1'b0;
      prio        <= 1'b0;
      s_addr      <= 32'h0;
      s_wdata     <= 32'h0;
      s_wstrb     <= 4'h0;
      cnt         <= '0;
      resp_data   <= 32'h0;
      err_timeout <= 1'b0;
    end else begin
      if (do_grant) begin
        grant   <= pick;
        prio    <= ~pick;
        s_addr  <= pick ? m1_addr  : m0_addr;
        s_wdata <= pick ? m1_wdata : m0_wdata;
        s_wstrb <= pick ? m1_wstrb : m0_wstrb;
        cnt     <= '0;
      end else if (state == BUSY && !s_ready) begin
        cnt <= cnt + CNT_WIDTH'(1);
      end

      if (done_ok)      resp_data <= s_rdata;
      else if (done_to) resp_data <= 32'h0;

      // a timeout in the same cycle as err_clear keeps the flag set
      if (done_to)        err_timeout <= 1'b1;
      else if (err_clear) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter, built with TIMEOUT_CYCLES=4.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset_n;
  logic        m0_valid, m1_valid;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        grant, err_timeout, err_clear;

  int vectors;
  int miscompares;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .grant(grant), .err_timeout(err_timeout), .err_clear(err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    #1;
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, " s_valid"}, {31'h0, s_valid}, 32'h0);
    check_output({tag, " m0_ready"}, {31'h0, m0_ready}, 32'h0);
    check_output({tag, " m1_ready"}, {31'h0, m1_ready}, 32'h0);
    check_output({tag, " m0_rdata"}, m0_rdata, 32'h0);
    check_output({tag, " m1_rdata"}, m1_rdata, 32'h0);
    check_output({tag, " s_addr"}, s_addr, 32'h0);
    check_output({tag, " s_wdata"}, s_wdata, 32'h0);
    check_output({tag, " s_wstrb"}, {28'h0, s_wstrb}, 32'h0);
    check_output({tag, " grant"}, {31'h0, grant}, 32'h0);
    check_output({tag, " err"}, {31'h0, err_timeout}, 32'h0);
  endtask

  initial begin
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic        exp_grant;

    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    m0_valid = 1'b0; m1_valid = 1'b0;
    m0_addr = 32'h0; m1_addr = 32'h0;
    m0_wdata = 32'h0; m1_wdata = 32'h0;
    m0_wstrb = 4'h0; m1_wstrb = 4'h0;
    s_ready = 1'b0; s_rdata = 32'h0; err_clear = 1'b0;

    tick();
    tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // single read, s_ready in the last timeout cycle (collision: data wins, no error)
    m0_valid = 1'b1; m0_addr = 32'h4000_0010;
    tick();
    check_output("rd s_valid", {31'h0, s_valid}, 32'h1);
    check_output("rd s_addr", s_addr, 32'h4000_0010);
    check_output("rd s_wstrb", {28'h0, s_wstrb}, 32'h0);
    tick();
    tick();
    tick();
    s_ready = 1'b1; s_rdata = 32'hCAFE_BABE;
    check_output("rd busy m0_ready", {31'h0, m0_ready}, 32'h0);
    tick();
    s_ready = 1'b0; s_rdata = 32'h0;
    check_output("rd m0_ready", {31'h0, m0_ready}, 32'h1);
    check_output("rd m0_rdata", m0_rdata, 32'hCAFE_BABE);
    check_output("rd m1_ready", {31'h0, m1_ready}, 32'h0);
    check_output("rd s_valid gap", {31'h0, s_valid}, 32'h0);
    check_output("rd collision err", {31'h0, err_timeout}, 32'h0);
    m0_valid = 1'b0;
    tick();
    check_output("rd pulse once", {31'h0, m0_ready}, 32'h0);
    check_output("rd rdata cleared", m0_rdata, 32'h0);

    // contention right after reset, then continuous alternation
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m0_valid = 1'b1; m1_valid = 1'b1;
    m0_addr = 32'h0000_0A00; m1_addr = 32'h0000_0B00;
    for (int i = 0; i < 8; i++) begin
      exp_grant = (i % 2) == 1;
      exp_addr  = exp_grant ? 32'h0000_0B00 : 32'h0000_0A00;
      exp_data  = 32'h1000_0000 + i;
      tick();
      check_output($sformatf("rr%0d grant", i), {31'h0, grant}, {31'h0, exp_grant});
      check_output($sformatf("rr%0d s_addr", i), s_addr, exp_addr);
      s_ready = 1'b1; s_rdata = exp_data;
      tick();
      s_ready = 1'b0; s_rdata = 32'h0;
      check_output($sformatf("rr%0d m0_ready", i), {31'h0, m0_ready}, {31'h0, !exp_grant});
      check_output($sformatf("rr%0d m1_ready", i), {31'h0, m1_ready}, {31'h0, exp_grant});
      check_output($sformatf("rr%0d rdata", i), exp_grant ? m1_rdata : m0_rdata, exp_data);
      check_output($sformatf("rr%0d idle rdata", i), exp_grant ? m0_rdata : m1_rdata, 32'h0);
      tick();
      check_output($sformatf("rr%0d gap", i), {31'h0, s_valid}, 32'h0);
    end
    m0_valid = 1'b0; m1_valid = 1'b0;

    // write pass-through; inputs changed while BUSY must be ignored
    m1_valid = 1'b1; m1_addr = 32'hC300_0004; m1_wdata = 32'h1234_5678; m1_wstrb = 4'b0011;
    tick();
    check_output("wr grant", {31'h0, grant}, 32'h1);
    check_output("wr s_addr", s_addr, 32'hC300_0004);
    check_output("wr s_wdata", s_wdata, 32'h1234_5678);
    check_output("wr s_wstrb", {28'h0, s_wstrb}, 32'h3);
    m1_addr = 32'hFFFF_FFFF; m1_wdata = 32'h0; m1_wstrb = 4'hF;
    tick();
    check_output("wr held s_addr", s_addr, 32'hC300_0004);
    check_output("wr held s_wdata", s_wdata, 32'h1234_5678);
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    check_output("wr m1_ready", {31'h0, m1_ready}, 32'h1);
    check_output("wr m0_ready", {31'h0, m0_ready}, 32'h0);
    m1_valid = 1'b0;
    tick();
    check_output("wr pulse once", {31'h0, m1_ready}, 32'h0);

    // timeout: s_valid high for exactly 4 cycles, then zero data and sticky error
    m0_valid = 1'b1; m0_addr = 32'h0000_0100; s_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_output($sformatf("to busy%0d s_valid", i), {31'h0, s_valid}, 32'h1);
      check_output($sformatf("to busy%0d m0_ready", i), {31'h0, m0_ready}, 32'h0);
    end
    tick();
    check_output("to s_valid", {31'h0, s_valid}, 32'h0);
    check_output("to m0_ready", {31'h0, m0_ready}, 32'h1);
    check_output("to m0_rdata", m0_rdata, 32'h0);
    check_output("to err", {31'h0, err_timeout}, 32'h1);
    m0_valid = 1'b0;
    tick();
    tick();
    check_output("to err sticky", {31'h0, err_timeout}, 32'h1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check_output("to err cleared", {31'h0, err_timeout}, 32'h0);

    // timeout in the same cycle as err_clear keeps the flag set
    err_clear = 1'b1; m0_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_output("toclr m0_ready", {31'h0, m0_ready}, 32'h1);
    check_output("toclr err wins", {31'h0, err_timeout}, 32'h1);
    m0_valid = 1'b0;
    tick();
    err_clear = 1'b0;
    check_output("toclr err cleared", {31'h0, err_timeout}, 32'h0);

    // requester drops valid before RESP: ready suppressed
    m0_valid = 1'b1; s_rdata = 32'h7777_7777;
    tick();
    m0_valid = 1'b0; s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    check_output("drop m0_ready", {31'h0, m0_ready}, 32'h0);
    check_output("drop m0_rdata", m0_rdata, 32'h0);
    tick();

    // reset while BUSY abandons the transaction
    m1_valid = 1'b1; m1_addr = 32'h0000_2222; m1_wdata = 32'h0000_3333; m1_wstrb = 4'h5;
    tick();
    check_output("rst busy s_valid", {31'h0, s_valid}, 32'h1);
    reset_n = 1'b0; s_ready = 1'b1; s_rdata = 32'h0000_0055; m1_valid = 1'b0;
    tick();
    reset_n = 1'b1; s_ready = 1'b0;
    check_reset_outputs("rst");
    tick();
    check_output("rst no late ready", {31'h0, m1_ready}, 32'h0);
    m1_valid = 1'b1; m1_addr = 32'h0000_4444;
    tick();
    check_output("post rst grant", {31'h0, grant}, 32'h1);
    check_output("post rst s_addr", s_addr, 32'h0000_4444);
    s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
    tick();
    s_ready = 1'b0;
    check_output("post rst m1_ready", {31'h0, m1_ready}, 32'h1);
    check_output("post rst m1_rdata", m1_rdata, 32'h0BAD_F00D);
    m1_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
